// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - scancodes, key classes and encodings for the calculator key entry
package calc_pkg;

  localparam logic [7:0] SC_0       = 8'h45;
  localparam logic [7:0] SC_1       = 8'h16;
  localparam logic [7:0] SC_2       = 8'h1E;
  localparam logic [7:0] SC_3       = 8'h26;
  localparam logic [7:0] SC_4       = 8'h25;
  localparam logic [7:0] SC_5       = 8'h2E;
  localparam logic [7:0] SC_6       = 8'h36;
  localparam logic [7:0] SC_7       = 8'h3D;
  localparam logic [7:0] SC_8       = 8'h3E;
  localparam logic [7:0] SC_9       = 8'h46;
  localparam logic [7:0] SC_ADD     = 8'h79;
  localparam logic [7:0] SC_SUB     = 8'h7B;
  localparam logic [7:0] SC_SUB_ALT = 8'h4E;
  localparam logic [7:0] SC_MUL     = 8'h7C;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_BKSP    = 8'h66;
  localparam logic [7:0] SC_ESC     = 8'h76;

  typedef enum logic [2:0] {DIGIT, OP, ENTER, BKSP, ESC, UNKNOWN} key_class_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    SHOW_RES = 2'b10
  } state_t;

endpackage

// File: rtl/kbd_key_decode.sv
// rtl/kbd_key_decode.sv - combinational PS/2 set-2 scancode to key class/digit/op decoder
module kbd_key_decode
  import calc_pkg::*;
(
  input  logic [7:0] scancode,
  output logic [2:0] key_class,
  output logic [3:0] digit,
  output logic [1:0] op_code
);

  always_comb begin
    key_class = UNKNOWN;
    digit     = 4'd0;
    op_code   = OP_NONE;
    case (scancode)
      SC_0:       begin key_class = DIGIT; digit = 4'd0; end
      SC_1:       begin key_class = DIGIT; digit = 4'd1; end
      SC_2:       begin key_class = DIGIT; digit = 4'd2; end
      SC_3:       begin key_class = DIGIT; digit = 4'd3; end
      SC_4:       begin key_class = DIGIT; digit = 4'd4; end
      SC_5:       begin key_class = DIGIT; digit = 4'd5; end
      SC_6:       begin key_class = DIGIT; digit = 4'd6; end
      SC_7:       begin key_class = DIGIT; digit = 4'd7; end
      SC_8:       begin key_class = DIGIT; digit = 4'd8; end
      SC_9:       begin key_class = DIGIT; digit = 4'd9; end
      SC_ADD:     begin key_class = OP; op_code = OP_ADD; end
      SC_SUB,
      SC_SUB_ALT: begin key_class = OP; op_code = OP_SUB; end
      SC_MUL:     begin key_class = OP; op_code = OP_MUL; end
      SC_ENTER:   key_class = ENTER;
      SC_BKSP:    key_class = BKSP;
      SC_ESC:     key_class = ESC;
      default:    key_class = UNKNOWN;
    endcase
  end

endmodule

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - keystroke-to-operand entry FSM with two-operand arithmetic
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int OW     = 10,
  parameter int RW     = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    scancode,
  input  logic          ready,
  output logic [RW-1:0] display,
  output logic [1:0]    op,
  output logic [1:0]    state,
  output logic [1:0]    ndig,
  output logic          reject
);

  localparam logic [1:0] MAX_DIG = 2'(DIGITS);

  logic [2:0]  kc_raw;
  key_class_t  kc;
  logic [3:0]  key_digit;
  logic [1:0]  key_op;

  kbd_key_decode u_decode (
    .scancode  (scancode),
    .key_class (kc_raw),
    .digit     (key_digit),
    .op_code   (key_op)
  );
  assign kc = key_class_t'(kc_raw);

  logic          ready_q;
  logic          key_ev;
  state_t        state_q;
  logic [OW-1:0] a_q, b_q;
  logic [1:0]    ndig_a_q;
  logic [RW-1:0] res_q;

  assign key_ev = ready & ~ready_q;
  assign state  = state_q;

  // Digit push/pop act on whichever operand is currently being edited.
  logic [OW-1:0] cur, push, pop;
  assign cur  = (state_q == ENTER_B) ? b_q : a_q;
  assign push = cur * OW'(10) + OW'(key_digit);
  assign pop  = cur / OW'(10);

  logic signed [RW-1:0] a_ext, b_ext, arith;
  assign a_ext = signed'(RW'(a_q));
  assign b_ext = signed'(RW'(b_q));

  always_comb begin
    arith = a_ext;
    case (op)
      OP_ADD:  arith = a_ext + b_ext;
      OP_SUB:  arith = a_ext - b_ext;
      OP_MUL:  arith = a_ext * b_ext;
      default: arith = a_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      state_q  <= ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      ndig_a_q <= 2'd0;
      res_q    <= '0;
      op       <= OP_NONE;
      ndig     <= 2'd0;
      display  <= '0;
      reject   <= 1'b0;
    end else begin
      ready_q <= ready;
      reject  <= 1'b0;
      if (key_ev) begin
        if (kc == ESC) begin
          state_q  <= ENTER_A;
          a_q      <= '0;
          b_q      <= '0;
          ndig_a_q <= 2'd0;
          res_q    <= '0;
          op       <= OP_NONE;
          ndig     <= 2'd0;
          display  <= '0;
        end else if (kc == UNKNOWN) begin
          reject <= 1'b1;
        end else begin
          case (state_q)
            ENTER_A: begin
              case (kc)
                DIGIT: if (ndig < MAX_DIG) begin
                  a_q     <= push;
                  ndig    <= ndig + 2'd1;
                  display <= RW'(push);
                end else reject <= 1'b1;
                OP: begin
                  op       <= key_op;
                  b_q      <= '0;
                  ndig_a_q <= ndig;
                  ndig     <= 2'd0;
                  display  <= '0;
                  state_q  <= ENTER_B;
                end
                ENTER: begin
                  res_q   <= RW'(a_q);
                  display <= RW'(a_q);
                  state_q <= SHOW_RES;
                end
                BKSP: if (ndig != 2'd0) begin
                  a_q     <= pop;
                  ndig    <= ndig - 2'd1;
                  display <= RW'(pop);
                end else reject <= 1'b1;
                default: ;
              endcase
            end
            ENTER_B: begin
              case (kc)
                DIGIT: if (ndig < MAX_DIG) begin
                  b_q     <= push;
                  ndig    <= ndig + 2'd1;
                  display <= RW'(push);
                end else reject <= 1'b1;
                OP: if (ndig == 2'd0) op <= key_op;
                    else reject <= 1'b1;
                ENTER: begin
                  res_q   <= arith;
                  display <= arith;
                  state_q <= SHOW_RES;
                end
                // Backspacing past an empty B drops the operator and resumes editing A.
                BKSP: if (ndig != 2'd0) begin
                  b_q     <= pop;
                  ndig    <= ndig - 2'd1;
                  display <= RW'(pop);
                end else begin
                  op      <= OP_NONE;
                  ndig    <= ndig_a_q;
                  display <= RW'(a_q);
                  state_q <= ENTER_A;
                end
                default: ;
              endcase
            end
            SHOW_RES: begin
              if (kc == DIGIT) begin
                a_q      <= OW'(key_digit);
                b_q      <= '0;
                ndig_a_q <= 2'd0;
                res_q    <= '0;
                op       <= OP_NONE;
                ndig     <= 2'd1;
                display  <= RW'(key_digit);
                state_q  <= ENTER_A;
              end else begin
                reject <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - self-checking bench for calc_key_entry with digit-queue model
module tb_calc_key_entry;

  localparam int RW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    scancode;
  logic          ready;
  logic [RW-1:0] display;
  logic [1:0]    op;
  logic [1:0]    state;
  logic [1:0]    ndig;
  logic          reject;

  calc_key_entry #(.DIGITS(3), .OW(10), .RW(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .scancode (scancode),
    .ready    (ready),
    .display  (display),
    .op       (op),
    .state    (state),
    .ndig     (ndig),
    .reject   (reject)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: each operand is the list of digits typed so far.
  int m_a[$];
  int m_b[$];
  int m_st;
  int m_op;
  int m_res;
  bit m_rej;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int val_a();
    int v = 0;
    foreach (m_a[i]) v = v * 10 + m_a[i];
    return v;
  endfunction

  function automatic int val_b();
    int v = 0;
    foreach (m_b[i]) v = v * 10 + m_b[i];
    return v;
  endfunction

  task automatic model_reset();
    m_a.delete();
    m_b.delete();
    m_st  = 0;
    m_op  = 0;
    m_res = 0;
    m_rej = 1'b0;
  endtask

  // kind: 0 digit, 1 operator, 2 enter, 3 backspace, 4 escape, 5 unknown
  task automatic decode(input logic [7:0] c, output int kind, output int v);
    kind = 0;
    v    = 0;
    case (c)
      8'h45: v = 0;  8'h16: v = 1;  8'h1E: v = 2;  8'h26: v = 3;  8'h25: v = 4;
      8'h2E: v = 5;  8'h36: v = 6;  8'h3D: v = 7;  8'h3E: v = 8;  8'h46: v = 9;
      8'h79: begin kind = 1; v = 1; end
      8'h7B, 8'h4E: begin kind = 1; v = 2; end
      8'h7C: begin kind = 1; v = 3; end
      8'h5A: kind = 2;
      8'h66: kind = 3;
      8'h76: kind = 4;
      default: kind = 5;
    endcase
  endtask

  task automatic model_apply(input logic [7:0] c);
    int kind, v;
    decode(c, kind, v);
    m_rej = 1'b0;
    if (kind == 4) model_reset();
    else if (kind == 5) m_rej = 1'b1;
    else if (m_st == 0) begin
      case (kind)
        0: if (m_a.size() < 3) m_a.push_back(v); else m_rej = 1'b1;
        1: begin m_op = v; m_b.delete(); m_st = 1; end
        2: begin m_res = val_a(); m_st = 2; end
        default: if (m_a.size() > 0) void'(m_a.pop_back()); else m_rej = 1'b1;
      endcase
    end else if (m_st == 1) begin
      case (kind)
        0: if (m_b.size() < 3) m_b.push_back(v); else m_rej = 1'b1;
        1: if (m_b.size() == 0) m_op = v; else m_rej = 1'b1;
        2: begin
          case (m_op)
            1: m_res = val_a() + val_b();
            2: m_res = val_a() - val_b();
            3: m_res = val_a() * val_b();
            default: m_res = val_a();
          endcase
          m_st = 2;
        end
        default: if (m_b.size() > 0) void'(m_b.pop_back());
                 else begin m_op = 0; m_st = 0; end
      endcase
    end else begin
      if (kind == 0) begin
        model_reset();
        m_a.push_back(v);
      end else m_rej = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int v;
      logic [31:0] e;
      v = (m_st == 0) ? val_a() : (m_st == 1) ? val_b() : m_res;
      e = 32'(v[RW-1:0]);
      chk("display", 32'(display), e);
      chk("state", 32'(state), 32'(m_st));
      chk("op", 32'(op), 32'(m_op));
      chk("reject", 32'(reject), 32'(m_rej));
      if (m_st == 0) chk("ndig_a", 32'(ndig), 32'(m_a.size()));
      if (m_st == 1) chk("ndig_b", 32'(ndig), 32'(m_b.size()));
    end
  end

  task automatic press(input logic [7:0] code, input int hold);
    @(negedge clk); #1;
    scancode = code;
    ready    = 1'b1;
    model_apply(code);
    @(negedge clk); #1;
    m_rej = 1'b0;
    repeat (hold - 1) @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic reset_with_key(input logic [7:0] code);
    @(negedge clk); #1;
    reset    = 1'b1;
    scancode = code;
    ready    = 1'b1;
    model_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    ready    = 1'b0;
    scancode = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_display", 32'(display), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_ndig", 32'(ndig), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    press(8'h16, 1); press(8'h1E, 1); press(8'h26, 1);
    chk("lit_123", 32'(display), 32'd123);
    chk("lit_ndig3", 32'(ndig), 32'd3);
    press(8'h25, 1);
    chk("lit_full_keeps_123", 32'(display), 32'd123);

    press(8'h76, 1);
    press(8'h26, 1); press(8'h79, 1); press(8'h25, 1); press(8'h5A, 1);
    chk("lit_state_show", 32'(state), 32'd2);
    chk("lit_3p4", 32'(display), 32'd7);
    press(8'h1E, 1); press(8'h7B, 1); press(8'h46, 1); press(8'h5A, 1);
    chk("lit_2m9", 32'(display), 32'h1F_FFF9);

    press(8'h46, 1); press(8'h46, 1); press(8'h46, 1); press(8'h7C, 1);
    press(8'h46, 1); press(8'h46, 1); press(8'h46, 1); press(8'h5A, 1);
    chk("lit_999x999", 32'(display), 32'd998001);

    press(8'h16, 1); press(8'h1E, 1); press(8'h66, 1);
    chk("lit_bksp_disp", 32'(display), 32'd1);
    chk("lit_bksp_ndig", 32'(ndig), 32'd1);
    press(8'h79, 1); press(8'h66, 1);
    chk("lit_back_state", 32'(state), 32'd0);
    chk("lit_back_op", 32'(op), 32'd0);
    chk("lit_back_ndig", 32'(ndig), 32'd1);
    chk("lit_back_disp", 32'(display), 32'd1);

    press(8'h76, 1);
    press(8'h16, 20);
    chk("lit_hold_one_digit", 32'(display), 32'd1);
    chk("lit_hold_ndig", 32'(ndig), 32'd1);
    press(8'h1C, 1);

    press(8'h25, 1); press(8'h79, 1); press(8'h16, 1); press(8'h76, 1);
    chk("lit_esc_disp", 32'(display), 32'd0);
    chk("lit_esc_state", 32'(state), 32'd0);
    chk("lit_esc_op", 32'(op), 32'd0);
    chk("lit_esc_ndig", 32'(ndig), 32'd0);

    press(8'h25, 1); press(8'h79, 1); press(8'h16, 1);
    reset_with_key(8'h16);
    chk("lit_rstkey_disp", 32'(display), 32'd0);
    chk("lit_rstkey_state", 32'(state), 32'd0);
    chk("lit_rstkey_ndig", 32'(ndig), 32'd0);
    press(8'h2E, 1);
    chk("lit_after_rst", 32'(display), 32'd5);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
# calc_key_entry

Keystroke-to-operand entry engine for the calculator, directly downstream of the PS/2 receiver. Each released-key scancode (PS/2 set 2) is decoded into a digit, operator or control key. The block builds two unsigned decimal operands and applies one operator. It presents the operand being edited, or the computed result, to the display stage.

## Interface
- `DIGITS`, default 3: maximum decimal digits per operand; operands range 0..10^DIGITS−1.
- `OW`, default 10: operand width in bits; must satisfy 2^OW > 10^DIGITS−1.
- `RW`, default 21: signed result width; must be ≥ 2·OW+1.

- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `scancode`  in  8: released-key code from the receiver; valid while `ready` is high.
- `ready`  in  1: new-key strobe from the receiver; only its rising edge is acted on.
- `display`  out  RW: signed value to show. A in ENTER_A, B in ENTER_B, result in SHOW_RES.
- `op`  out  2: current operator: 00 none, 01 add, 10 sub, 11 mul.
- `state`  out  2: 00 ENTER_A, 01 ENTER_B, 10 SHOW_RES.
- `ndig`  out  2: digits entered in the current operand, 0..DIGITS.
- `reject`  out  1: one-cycle pulse when a key is ignored or the scancode is unknown.

## Operation
- Key decode (set 2):
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Operators: 79 = add; 7B and 4E = sub; 7C = mul.
  - Control: 5A = enter, 66 = backspace, 76 = escape.
  - Any other code is unknown.
- A key event is `ready & ~ready_q`, where `ready_q` is `ready` registered. A `ready` held high is therefore one key.
- Reset: state=ENTER_A, A=B=0, result=0, `op`=00, `ndig`=0, `display`=0, `reject`=0, `ready_q`=0.
- ENTER_A:
  - digit: if `ndig`<DIGITS then A←A·10+d and `ndig`+1; else `reject`.
  - operator: `op`←code, B←0, `ndig`←0, go to ENTER_B.
  - enter: result←A, go to SHOW_RES.
  - backspace: if `ndig`>0 then A←A/10 and `ndig`−1; else `reject`.
- ENTER_B:
  - digit: same rule as ENTER_A, applied to B.
  - operator: replaces `op` only if `ndig`=0; else `reject`.
  - enter: result←A op B (sign-extended to RW; sub may go negative), go to SHOW_RES.
  - backspace: if `ndig`>0 then edit B; if `ndig`=0 then `op`←00, restore `ndig` to the digit count of A, return to ENTER_A.
- SHOW_RES:
  - digit: clear everything, A←d, `ndig`=1, go to ENTER_A.
  - operator, enter, backspace: `reject`, no state change.
- Escape in any state behaves exactly as reset, except `ready_q` keeps tracking `ready`.
- Unknown code in any state: `reject`, nothing else changes.
- Arithmetic is full-precision; overflow is impossible given the RW constraint.

## Timing
- Key event detected in cycle n. All outputs reflect its effect after the clk edge ending cycle n, a latency of one edge.
- `reject` is high exactly one cycle for each rejected event.
- Consecutive key events require `ready` to go low for at least one cycle between them.
- If `reset` and a key event coincide, `reset` wins.
- Escape coinciding with nothing else needs no special handling; there is only one key per event.
- `display` is registered; no combinational path from `scancode` to any output.

## Structure
- Package `calc_pkg` holds:
  - the scancode constants;
  - the key-class enum: DIGIT, OP, ENTER, BKSP, ESC, UNKNOWN;
  - the `op` and `state` encodings.
- Sub-module `kbd_key_decode` is purely combinational. It maps `scancode` to key class, a 4-bit digit value and a 2-bit op code.
- The top level holds the edge detector, the FSM, the operand and digit-count registers, and the arithmetic unit.

## Test plan
- Reset, then keys 16,1E,26 → `display`=123, `ndig`=3. A fourth digit 25 → `reject` pulse, `display` stays 123.
- Keys 26,79,25,5A (3+4, enter) → `state`=SHOW_RES, `display`=7. Then keys 1E,7B,46,5A (2−9) → `display`=−7 (two's complement across RW).
- Keys 46,46,46,7C,46,46,46,5A (999·999) → `display`=998001.
- Keys 16,1E,66 → `display`=1, `ndig`=1. Then 79,66 → back to ENTER_A with `op`=00, `ndig`=1, `display`=1.
- Hold `ready` high 20 cycles with code 16 → exactly one digit entered. Unknown code 1C → `reject` for 1 cycle only.
- Mid-entry of B (keys 25,79,16), key 76 → all outputs at their reset values. Repeat the sequence but assert `reset` in the same cycle as a key event → reset values, key ignored.
